// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg
// Shared types and helpers for the multi-cycle RV32I/RV64I ALU.
//   alu_op_e     : 5-bit operation code carried on ALU_Op
//   alu_state_e  : IDLE / BUSY / DONE controller states
//   ALU_OP_W     : width of the operation code
//   is_shift, is_muldiv, is_legal, is_iterative : opcode classification
// Optional feature macro: RISCV_ALU_MULDIV_EN (makes MUL/DIV/DIVU/REM/REMU legal).

package riscv_alu_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLT  = 5'd5,
        OP_SLTU = 5'd6,
        OP_SLL  = 5'd7,
        OP_SRL  = 5'd8,
        OP_SRA  = 5'd9,
        OP_MUL  = 5'd10,
        OP_DIV  = 5'd11,
        OP_DIVU = 5'd12,
        OP_REM  = 5'd13,
        OP_REMU = 5'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    // Codes 10-14 only exist when the multiply/divide unit is built.
    function automatic logic is_legal(input logic [ALU_OP_W-1:0] op);
`ifdef RISCV_ALU_MULDIV_EN
        return op <= OP_REMU;
`else
        return op <= OP_SRA;
`endif
    endfunction

    // Ops that may need BUSY cycles; a zero-amount shift still finishes in one.
    function automatic logic is_iterative(input logic [ALU_OP_W-1:0] op);
`ifdef RISCV_ALU_MULDIV_EN
        return is_shift(op) || is_muldiv(op);
`else
        return is_shift(op);
`endif
    endfunction

endpackage

// File: rtl/riscv_alu_mc_if.sv
// riscv_alu_mc_if
// Operand/result handshake bundle between the execute stage and the ALU.
//   In_Valid / In_Ready   : operation handshake (master -> ALU)
//   ALU_Op, Op_A, Op_B    : operation code and pre-muxed operands
//   Out_Valid / Out_Ready : result handshake (ALU -> master)
//   ALU_Out, Zero, Illegal: registered result, zero flag, unsupported-op flag
// Modports: master (execute stage side), slave (ALU side).

interface riscv_alu_mc_if #(
    parameter int XLEN = 32
);

    logic                                In_Valid;
    logic                                In_Ready;
    logic [riscv_alu_pkg::ALU_OP_W-1:0]  ALU_Op;
    logic [XLEN-1:0]                     Op_A;
    logic [XLEN-1:0]                     Op_B;
    logic                                Out_Valid;
    logic                                Out_Ready;
    logic [XLEN-1:0]                     ALU_Out;
    logic                                Zero;
    logic                                Illegal;

    modport master (
        output In_Valid, ALU_Op, Op_A, Op_B, Out_Ready,
        input  In_Ready, Out_Valid, ALU_Out, Zero, Illegal
    );

    modport slave (
        input  In_Valid, ALU_Op, Op_A, Op_B, Out_Ready,
        output In_Ready, Out_Valid, ALU_Out, Zero, Illegal
    );

endinterface

// File: rtl/riscv_muldiv_iter.sv
// riscv_muldiv_iter
// Iterative shift-add multiplier and restoring divider sharing one set of
// accumulator registers. Signed divide/remainder run on magnitudes and the
// sign is restored on the final iteration.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : one-cycle pulse, captures op/a/b
//   op         : MUL, DIV, DIVU, REM or REMU
//   a, b       : operands
//   done       : high during the last iteration; result valid in that cycle
//   result     : low XLEN product, quotient or remainder
// Only instantiated when RISCV_ALU_MULDIV_EN is defined.

module riscv_muldiv_iter
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ALU_OP_W-1:0]  op,
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    output logic                 done,
    output logic [XLEN-1:0]      result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic             active_q;
    logic [CW-1:0]    cnt_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  opnd_q;
    logic             is_mul_q;
    logic             want_rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    diff;
    logic             fits;
    logic [XLEN-1:0]  mul_next;
    logic [XLEN-1:0]  rem_next;
    logic [XLEN-1:0]  quo_next;

    // Operand magnitudes for signed division; the most-negative value maps
    // onto itself, which the unsigned core treats as 2^(XLEN-1).
    always_comb begin
        signed_op = (op == OP_DIV) || (op == OP_REM);
        a_neg     = signed_op && a[XLEN-1];
        b_neg     = signed_op && b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // One iteration of either algorithm. hi holds the product accumulator or
    // the partial remainder; lo holds the multiplier or the dividend bits
    // being replaced by quotient bits; opnd holds multiplicand or divisor.
    always_comb begin
        mul_next  = hi_q + (lo_q[0] ? opnd_q : '0);
        rem_shift = {hi_q, lo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, opnd_q};
        fits      = !diff[XLEN];
        rem_next  = fits ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next  = {lo_q[XLEN-2:0], fits};
        if (is_mul_q) begin
            result = mul_next;
        end else if (want_rem_q) begin
            result = neg_rem_q ? -rem_next : rem_next;
        end else begin
            result = neg_quo_q ? -quo_next : quo_next;
        end
    end

    assign done = active_q && (cnt_q == LAST);

    // Divide by zero leaves the quotient all-ones; its sign is not flipped so
    // a signed DIV by zero also returns all-ones. The remainder keeps the
    // dividend's sign, which restores the original dividend in that case.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            is_mul_q   <= 1'b0;
            want_rem_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (start) begin
            active_q   <= 1'b1;
            cnt_q      <= '0;
            hi_q       <= '0;
            is_mul_q   <= (op == OP_MUL);
            want_rem_q <= (op == OP_REM) || (op == OP_REMU);
            neg_quo_q  <= (a_neg ^ b_neg) && (b != '0);
            neg_rem_q  <= a_neg;
            if (op == OP_MUL) begin
                lo_q   <= b;
                opnd_q <= a;
            end else begin
                lo_q   <= a_mag;
                opnd_q <= b_mag;
            end
        end else if (active_q) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                active_q <= 1'b0;
            end
            if (is_mul_q) begin
                hi_q   <= mul_next;
                lo_q   <= lo_q >> 1;
                opnd_q <= opnd_q << 1;
            end else begin
                hi_q   <= rem_next;
                lo_q   <= quo_next;
            end
        end
    end

endmodule

// File: rtl/riscv_alu_mc.sv
// riscv_alu_mc
// Multi-cycle RV32I/RV64I ALU behind a valid/ready handshake. Logic and
// compare ops finish one cycle after accept; shifts move SHIFT_STEP bits per
// BUSY cycle; optional MUL/DIV/REM run XLEN BUSY cycles in riscv_muldiv_iter.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : riscv_alu_mc_if slave modport (operation in, result out)
// Parameters: XLEN (32 or 64), SHIFT_STEP (power of two, 1..XLEN).
// Optional feature macro: RISCV_ALU_MULDIV_EN.

module riscv_alu_mc
    import riscv_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    riscv_alu_mc_if.slave  bus
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] STEP = SHIFT_STEP[SHW:0];

    alu_state_e           state_q;
    alu_state_e           state_d;
    logic [ALU_OP_W-1:0]  op_q;
    logic [XLEN-1:0]      work_q;
    logic                 sign_q;
    logic [SHW:0]         cnt_q;
    logic [XLEN-1:0]      out_q;
    logic                 zero_q;
    logic                 illegal_q;

    logic                 accept;
    logic [ALU_OP_W-1:0]  in_op;
    logic [SHW:0]         in_shamt;
    logic                 in_legal;
    logic                 in_short;
    logic [XLEN-1:0]      quick_res;
    logic [XLEN-1:0]      start_res;

    logic [SHW:0]         step;
    logic [SHW:0]         cnt_next;
    logic                 shift_last;
    logic [XLEN-1:0]      fill_mask;
    logic [XLEN-1:0]      shifted;
    logic                 busy_finish;
    logic [XLEN-1:0]      busy_res;

    assign accept   = bus.In_Valid && (state_q == ST_IDLE);
    assign in_op    = bus.ALU_Op;
    assign in_shamt = {1'b0, bus.Op_B[SHW-1:0]};
    assign in_legal = is_legal(in_op);

    // An op finishes straight from IDLE when it is illegal, non-iterative,
    // or a shift by zero (whose result is just Op_A).
    assign in_short = !in_legal || !is_iterative(in_op) ||
                      (is_shift(in_op) && (in_shamt == '0));

    // Single-cycle results, evaluated on the live operands at accept.
    always_comb begin
        quick_res = '0;
        case (in_op)
            OP_ADD:  quick_res = bus.Op_A + bus.Op_B;
            OP_SUB:  quick_res = bus.Op_A - bus.Op_B;
            OP_AND:  quick_res = bus.Op_A & bus.Op_B;
            OP_OR:   quick_res = bus.Op_A | bus.Op_B;
            OP_XOR:  quick_res = bus.Op_A ^ bus.Op_B;
            OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, ($signed(bus.Op_A) < $signed(bus.Op_B))};
            OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, (bus.Op_A < bus.Op_B)};
            OP_SLL, OP_SRL, OP_SRA: quick_res = bus.Op_A;
            default: quick_res = '0;
        endcase
    end

    assign start_res = in_legal ? quick_res : '0;

    // Iterative shifter: each BUSY cycle moves min(SHIFT_STEP, remaining)
    // bits. SRA fills from the sign captured at accept, not from work_q.
    always_comb begin
        step       = (cnt_q > STEP) ? STEP : cnt_q;
        cnt_next   = cnt_q - step;
        shift_last = (cnt_next == '0);
        fill_mask  = sign_q ? ~({XLEN{1'b1}} >> step) : '0;
        shifted    = work_q >> step;
        case (op_q)
            OP_SLL:  shifted = work_q << step;
            OP_SRL:  shifted = work_q >> step;
            default: shifted = (work_q >> step) | fill_mask;
        endcase
    end

`ifdef RISCV_ALU_MULDIV_EN
    logic             md_start;
    logic             md_done;
    logic [XLEN-1:0]  md_result;

    assign md_start = accept && is_muldiv(in_op);

    riscv_muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (in_op),
        .a      (bus.Op_A),
        .b      (bus.Op_B),
        .done   (md_done),
        .result (md_result)
    );

    assign busy_finish = is_shift(op_q) ? shift_last : md_done;
    assign busy_res    = is_shift(op_q) ? shifted    : md_result;
`else
    assign busy_finish = shift_last;
    assign busy_res    = shifted;
`endif

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. DONE leaves for IDLE on Out_Ready,
    // so no new op can be accepted in the same cycle a result is taken.
    always_comb begin
        state_d       = state_q;
        bus.In_Ready  = 1'b0;
        bus.Out_Valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.In_Ready = 1'b1;
                if (accept) begin
                    state_d = in_short ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (busy_finish) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.Out_Valid = 1'b1;
                if (bus.Out_Ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, shift iteration and result registers. The result
    // registers only change when an op completes, so they hold steady
    // while DONE waits on Out_Ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            work_q    <= '0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            out_q     <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else if (accept) begin
            op_q   <= in_op;
            work_q <= bus.Op_A;
            sign_q <= bus.Op_A[XLEN-1];
            cnt_q  <= in_shamt;
            if (in_short) begin
                out_q     <= start_res;
                zero_q    <= (start_res == '0);
                illegal_q <= !in_legal;
            end
        end else if (state_q == ST_BUSY) begin
            if (is_shift(op_q)) begin
                work_q <= shifted;
                cnt_q  <= cnt_next;
            end
            if (busy_finish) begin
                out_q     <= busy_res;
                zero_q    <= (busy_res == '0);
                illegal_q <= 1'b0;
            end
        end
    end

    assign bus.ALU_Out = out_q;
    assign bus.Zero    = zero_q;
    assign bus.Illegal = illegal_q;

endmodule
